// File: rtl/run_monitor.sv
// Purpose: folds the datapath PC/Instr/store bus into a signature hash and a pass/fail/timeout verdict.
// Latency: hash, counters and verdict flags are registered and are visible one cycle after the sampled inputs.
// Backpressure: none; it samples on every RUN edge and ignores all inputs once a verdict is reached.
module run_monitor #(
  parameter logic [31:0] PASS_ADDR   = 32'd100,
  parameter logic [31:0] PASS_DATA   = 32'd25,
  parameter logic [31:0] IGNORE_ADDR = 32'd96,
  parameter int unsigned TIMEOUT     = 10000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [31:0]       PC,
  input  logic [31:0]       Instr,
  input  logic              MemWrite,
  input  logic [31:0]       DataAdr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       hash,
  output logic [CNT_W-1:0]  cycles,
  output logic [CNT_W-1:0]  writes,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  // Cycle count seen on the edge that must raise the timeout verdict.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q;
  logic [31:0]      hash_q, hash_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] writes_q, writes_d;
  logic             done_q, pass_q, fail_q, timeout_q;

  logic [31:0]      mix;
  logic             ign_wr, pass_hit, fail_hit, to_hit;

  // Next hash/counter values and the store/timeout qualifiers for a RUN edge.
  always_comb begin
    mix      = hash_q ^ Instr ^ PC;
    if (MemWrite) begin
      mix = mix ^ WriteData;
    end
    hash_d   = {mix[30:0], mix[9] ^ mix[29] ^ mix[30] ^ mix[31]};
    ign_wr   = MemWrite && (DataAdr == IGNORE_ADDR);
    // Counters stick at all-ones rather than wrapping back to zero.
    cycles_d = (&cycles_q) ? cycles_q : cycles_q + CNT_ONE;
    writes_d = (ign_wr && !(&writes_q)) ? writes_q + CNT_ONE : writes_q;
    // A wrong-data store to PASS_ADDR falls through to fail_hit.
    pass_hit = MemWrite && (DataAdr == PASS_ADDR) && (WriteData == PASS_DATA);
    fail_hit = MemWrite && (DataAdr != IGNORE_ADDR);
    to_hit   = (cycles_q == TO_LAST);
  end

  // Run-state machine: owns the signature, counters and registered verdict flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      hash_q    <= '0;
      cycles_q  <= '0;
      writes_q  <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // The start edge itself is not sampled.
          if (en) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          // The verdict edge still folds its inputs into the hash and counters.
          hash_q   <= hash_d;
          cycles_q <= cycles_d;
          writes_q <= writes_d;
          if (pass_hit) begin
            state_q <= S_PASS;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end else if (fail_hit) begin
            state_q <= S_FAIL;
            done_q  <= 1'b1;
            fail_q  <= 1'b1;
          end else if (to_hit) begin
            state_q   <= S_TIMEOUT;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        S_PASS, S_FAIL, S_TIMEOUT: begin
          // Terminal: everything holds until reset.
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign hash    = hash_q;
  assign cycles  = cycles_q;
  assign writes  = writes_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign fail    = fail_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_run_monitor.sv
// Purpose: randomized and directed stimulus for run_monitor, checked against a behavioural reference.
// Latency: expectations are queued at stimulus time and popped just after the edge that should produce them.
// Backpressure: not applicable; one expectation per driven cycle plus one per asynchronous reset check.
module tb_run_monitor;

  localparam int unsigned TO = 8;

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] PC, Instr, DataAdr, WriteData;
  logic        MemWrite;
  logic [31:0] hash, cycles, writes;
  logic        done, pass, fail, timeout;

  run_monitor #(
    .PASS_ADDR  (32'd100),
    .PASS_DATA  (32'd25),
    .IGNORE_ADDR(32'd96),
    .TIMEOUT    (TO),
    .CNT_W      (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .PC       (PC),
    .Instr    (Instr),
    .MemWrite (MemWrite),
    .DataAdr  (DataAdr),
    .WriteData(WriteData),
    .hash     (hash),
    .cycles   (cycles),
    .writes   (writes),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .timeout  (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] hash;
    logic [31:0] cycles;
    logic [31:0] writes;
    logic [3:0]  flags;   // {done, pass, fail, timeout}
    int          step;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;
  event sample_ev;

  // Reference model: a run is "started", then counts samples until a verdict code is set.
  bit          m_started;
  int          m_verdict;   // 0 none, 1 pass, 2 fail, 3 timeout
  logic [31:0] m_hash;
  int unsigned m_cycles, m_writes;

  function automatic void model_reset();
    m_started = 0;
    m_verdict = 0;
    m_hash    = 32'd0;
    m_cycles  = 0;
    m_writes  = 0;
  endfunction

  function automatic void model_step(logic e, logic mw, logic [31:0] adr, logic [31:0] wd,
                                     logic [31:0] pc, logic [31:0] ins);
    logic [31:0] t;
    if (m_verdict != 0) return;
    if (!m_started) begin
      if (e) m_started = 1;
      return;
    end
    t = m_hash ^ ins ^ pc;
    if (mw) t = t ^ wd;
    m_hash = (t << 1) | {31'd0, ^(t & 32'hE000_0200)};
    m_cycles = m_cycles + 1;
    if (mw && adr == 32'd96) m_writes = m_writes + 1;
    if (mw && adr == 32'd100 && wd == 32'd25) m_verdict = 1;
    else if (mw && adr != 32'd96)             m_verdict = 2;
    else if (m_cycles == TO)                  m_verdict = 3;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.hash   = m_hash;
    e.cycles = m_cycles;
    e.writes = m_writes;
    e.flags  = {m_verdict != 0, m_verdict == 1, m_verdict == 2, m_verdict == 3};
    e.step   = step_no;
    step_no++;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string nm, input int step, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, step, act, expv);
    end
  endtask

  // Sample point for clocked expectations: just after each rising edge.
  always @(posedge clk) begin
    #1;
    -> sample_ev;
  end

  // Monitor: pops one expectation per sample event and compares every output.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hash",   e.step, hash,   e.hash);
        chk("cycles", e.step, cycles, e.cycles);
        chk("writes", e.step, writes, e.writes);
        chk("flags",  e.step, {28'd0, done, pass, fail, timeout}, {28'd0, e.flags});
      end
    end
  end

  // One driven cycle: inputs change on the falling edge, expectation covers the next rising edge.
  task automatic cyc(input logic e, input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                     input logic [31:0] pc, input logic [31:0] ins);
    @(negedge clk);
    reset = 1'b1; en = e; MemWrite = mw; DataAdr = adr; WriteData = wd; PC = pc; Instr = ins;
    model_step(e, mw, adr, wd, pc, ins);
    push_exp();
  endtask

  // Asynchronous reset between edges; outputs must already be zero before the next edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; en = 1'b0; MemWrite = 1'b0;
    model_reset();
    push_exp();
    #2;
    -> sample_ev;
  endtask

  function automatic logic [31:0] pick_adr();
    case ($urandom_range(0, 3))
      0:       return 32'd96;
      1:       return 32'd100;
      2:       return 32'd200;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] pick_wd();
    case ($urandom_range(0, 2))
      0:       return 32'd25;
      1:       return 32'd24;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_cyc(input logic e);
    cyc(e, $urandom_range(0, 3) == 0, pick_adr(), pick_wd(), $urandom, $urandom);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; MemWrite = 1'b0;
    PC = '0; Instr = '0; DataAdr = '0; WriteData = '0;
    model_reset();

    // Reset values, then hash steps, a tolerated write and a pass followed by ignored stores.
    do_reset();
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'h13);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 32'd4, 32'h13);
    cyc(1'b0, 1'b1, 32'd96, 32'd7, 32'd8, 32'h13);
    cyc(1'b0, 1'b1, 32'd100, 32'd25, 32'd12, 32'h13);
    cyc(1'b0, 1'b1, 32'd100, 32'd24, 32'd16, 32'h13);
    cyc(1'b1, 1'b1, 32'd200, 32'd1, 32'd20, 32'h33);

    // Wrong data at the pass address.
    do_reset();
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'h13);
    cyc(1'b0, 1'b1, 32'd100, 32'd24, 32'd4, 32'h23);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 32'd8, 32'h13);

    // Store to an unrelated address.
    do_reset();
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    cyc(1'b0, 1'b1, 32'd200, 32'd25, 32'd0, 32'h23);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 32'd4, 32'h13);

    // Timeout after TO quiet samples, then pass store on exactly the last sample.
    do_reset();
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < TO + 2; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0, 32'(4 * i), 32'h13);
    do_reset();
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < TO - 1; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0, 32'(4 * i), 32'h13);
    cyc(1'b0, 1'b1, 32'd100, 32'd25, 32'd28, 32'h23);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 32'd32, 32'h13);

    // Reset three samples into a run, then stay idle with en low.
    do_reset();
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0, 32'(4 * i), 32'h13);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'd100, 32'd25, 32'(4 * i), 32'h13);

    // Randomized runs: idle gap, start edge with random inputs, random mix of stores.
    for (int r = 0; r < 40; r++) begin
      int idle_n, run_n;
      do_reset();
      idle_n = $urandom_range(0, 2);
      run_n  = $urandom_range(3, 12);
      for (int i = 0; i < idle_n; i++) rand_cyc(1'b0);
      rand_cyc(1'b1);
      for (int i = 0; i < run_n; i++) rand_cyc($urandom_range(0, 1) == 1);
    end

    // Every queued expectation must have been consumed.
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
- Synthesizable run checker. Sits directly downstream of the multi-cycle RISC-V top and consumes its PC, Instr and memory-write bus every cycle.
- Folds these into a 32-bit signature hash and decides pass, fail or timeout from the first qualifying data-memory write.
- Lets self-checking runs execute on FPGA or in emulation without a behavioural bench.

Parameters:
- PASS_ADDR, 32'd100: store address that ends the run.
- PASS_DATA, 32'd25: data value required at PASS_ADDR for a pass.
- IGNORE_ADDR, 32'd96: store address that is always tolerated; never ends the run.
- TIMEOUT, 10000: maximum number of RUN cycles before the timeout verdict; minimum 1.
- CNT_W, 32: width of the cycle and write counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  start sampling; checked only in IDLE.
- PC  in  32  current program counter from the datapath.
- Instr  in  32  current instruction register from the datapath.
- MemWrite  in  1  data-memory write strobe.
- DataAdr  in  32  data-memory address.
- WriteData  in  32  data-memory write data.
- hash  out  32  running signature.
- cycles  out  CNT_W  RUN cycles sampled.
- writes  out  CNT_W  tolerated writes to IGNORE_ADDR.
- done  out  1  a verdict has been reached.
- pass  out  1  verdict is pass.
- fail  out  1  verdict is fail.
- timeout  out  1  verdict is timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - hash=0, cycles=0, writes=0.
  - done, pass, fail and timeout all 0.
- States and transitions:
  - IDLE -> RUN on the rising edge where en=1. No sampling occurs on that edge.
  - RUN samples the inputs on every rising edge.
  - PASS, FAIL and TIMEOUT are terminal. They hold every output until reset.
- RUN edge, hash step (computed on the pre-edge value h):
  - t = h ^ Instr ^ PC.
  - If MemWrite, t = t ^ WriteData.
  - hash <= {t[30:0], t[9]^t[29]^t[30]^t[31]}.
- RUN edge, counters:
  - cycles <= cycles+1.
  - writes <= writes+1 if MemWrite and DataAdr==IGNORE_ADDR.
  - Both counters saturate at all-ones; they never wrap.
- RUN edge, verdict priority (highest first):
  1. MemWrite and DataAdr==PASS_ADDR and WriteData==PASS_DATA -> PASS.
  2. MemWrite and DataAdr!=IGNORE_ADDR -> FAIL. This covers PASS_ADDR with wrong data.
  3. cycles==TIMEOUT-1 with no store verdict on this edge -> TIMEOUT.
  4. Otherwise stay in RUN.
- The verdict edge still performs the hash and counter updates, so the final hash includes the terminal cycle.
- Verdict flags (done and the matching pass/fail/timeout) are registered. They rise one cycle after the qualifying inputs are presented, i.e. they are visible after the verdict edge. Exactly one of pass/fail/timeout is 1 whenever done=1.
- Terminal states: inputs are ignored; hash, cycles and writes freeze.
- en is don't-care outside IDLE.
- Reset asserted mid-RUN or in a terminal state returns to the reset values immediately, without waiting for a clock edge.
- Deassertion of reset is assumed synchronous to clk upstream; no internal synchronizer.

Test Plan:
- Hash step: reset, en=1, then two RUN edges with no write.
  - Instr=0x00000013, PC=0 -> hash=0x00000026.
  - Then Instr=0x00000013, PC=4 -> hash=0x00000062.
  - Both edges: cycles increments to 2; done=0 throughout.
- Tolerated write: in RUN, MemWrite=1, DataAdr=96, WriteData=7 -> state stays RUN, writes=1, done=0; hash includes the 0x7 XOR.
- Pass: in RUN, MemWrite=1, DataAdr=100, WriteData=25 -> next cycle done=1, pass=1, fail=0.
  - Further MemWrite with DataAdr=100, WriteData=24 changes nothing; hash frozen.
- Fail: MemWrite=1, DataAdr=100, WriteData=24 -> done=1, fail=1.
  - Separate run: DataAdr=200 with any data -> fail=1.
- Timeout (TIMEOUT=8): in RUN, no stores for 8 edges -> timeout=1, done=1, cycles=8.
  - Variant: a store of 25 to address 100 on the 8th edge -> pass=1, not timeout.
- Reset mid-run: assert reset between clock edges after 3 RUN cycles -> all outputs 0 before the next edge.
  - Release reset, keep en=0 -> module stays in IDLE, counters remain 0.
